rotation_line_parser: RTL
=========================

Name: rotation_line_parser

Overview:
- Upstream stage of the dial accumulator.
- Consumes the puzzle input as an ASCII byte stream, one rotation per line in the form `L68` / `R5`.
- Converts each line into the direction bit, two-digit BCD remainder and BCD hundreds digit that the accumulator consumes.
- The accumulator has no valid input and updates every cycle, so all rotation outputs are forced to zero whenever no rotation is being presented. An idle cycle is therefore an R+00 no-op downstream.

Parameters:
- CNT_W, default 16, width of the emitted-rotation counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_byte  in  8  ASCII input byte
- in_valid  in  1  in_byte is present this cycle
- in_last  in  1  qualifies in_byte as the final byte of the file
- in_ready  out  1  parser accepts a byte when in_valid && in_ready
- rot_valid  out  1  one-cycle pulse: rotation outputs are meaningful
- R_L  out  1  0 = R, 1 = L; 0 when !rot_valid
- BCD_val  out  8  tens:ones BCD digits of the magnitude; 0 when !rot_valid
- BCD_mod  out  4  hundreds BCD digit of the magnitude; 0 when !rot_valid
- rot_count  out  CNT_W  number of rotations emitted since reset
- done  out  1  one-cycle pulse after the in_last byte has been processed
- err_syntax  out  1  sticky: malformed line seen
- err_overflow  out  1  sticky: magnitude exceeded 999

Behaviour:
- Reset values:
  - in_ready=0, rot_valid=0, R_L=0, BCD_val=0, BCD_mod=0, rot_count=0, done=0, err_*=0.
  - State=IDLE, digit registers cleared.
- in_ready is registered and goes to 1 in the first cycle after rst deasserts. It then stays 1 with no backpressure; one byte is accepted per handshake cycle.
- All outputs are registered. A terminator accepted in cycle N gives rot_valid=1 in cycle N+1 only.
- Rotation outputs are zero in every cycle where rot_valid=0.
- State IDLE:
  - 'L' (0x4C) or 'R' (0x52): latch dir, clear h/t/o digits and the digit-seen flag, go to DIGITS.
  - '\n' (0x0A) or '\r' (0x0D): ignored, blank lines allowed.
  - Any other byte: set err_syntax, go to SKIP.
- State DIGITS:
  - '0'..'9': shift in, h<=t, t<=o, o<=byte-0x30. If h!=0 before the shift, set err_overflow; the low three digits are kept.
  - '\r': ignored.
  - '\n' with at least one digit seen: emit next cycle with R_L=dir, BCD_val={t,o}, BCD_mod=h; rot_count increments in that same cycle; go to IDLE.
  - '\n' with no digit: set err_syntax, no emit, go to IDLE.
  - Any other byte: set err_syntax, go to SKIP.
- State SKIP: discard bytes until '\n', then go to IDLE. No emit.
- in_last:
  - The byte is first processed normally.
  - If the parser is then in DIGITS with a digit seen, it emits as if '\n' had followed.
  - If it is in DIGITS with no digit, err_syntax is set.
  - done pulses in the same cycle as that final emit, or in cycle N+1 if there is no emit. State returns to IDLE; further input starts a new file.
- Zero magnitude ("L0", "R000") is valid: rot_valid=1 with zero outputs, and rot_count increments.
- rot_count wraps modulo 2^CNT_W.
- rst mid-line drops the partial line with no emit, and clears the counters and sticky errors.

Decomposition:
- Shared package `dial_pkg`:
  - ASCII constants CH_L, CH_R, CH_LF, CH_CR, CH_0, CH_9.
  - State enum IDLE/DIGITS/SKIP.
  - BCD digit typedef (4 bits).
- One natural sub-module, `bcd_digit_shift3`: 3-digit BCD shift register with clear, shift-enable and overflow-out. Everything else stays inline.

Test Plan:
- Stream "L68\nR5\n", contiguous valid -> two rot_valid pulses, each one cycle after its '\n': (R_L=1, BCD_val=0x68, BCD_mod=0), then (R_L=0, BCD_val=0x05, BCD_mod=0); rot_count=2; all rotation outputs 0 between pulses.
- "R1234\n" -> err_overflow=1, emit R_L=0, BCD_val=0x34, BCD_mod=2; "L999\r\n" -> BCD_val=0x99, BCD_mod=9, '\r' ignored.
- "X12\nL\nR7\n" -> err_syntax=1, exactly one emit (R, 0x07, 0), rot_count=1.
- "L50" with in_last on '0', in_valid gaps between bytes -> single emit (L, 0x50, 0) with done pulsing the same cycle; "\n\nR0\n" -> blank lines ignored, emit (R, 0x00, 0), rot_count=1.
- rst asserted after "L4" -> no emit, all outputs back to reset values, in_ready=0 during rst and 1 the cycle after; a following "R3\n" emits (R, 0x03, 0) with rot_count=1.

Source files
------------

// File: rtl/dial_pkg.sv
// rtl/dial_pkg.sv - shared constants and types for the dial rotation front end
package dial_pkg;

  // ASCII bytes the line parser recognises
  localparam logic [7:0] CH_L  = 8'h4C;
  localparam logic [7:0] CH_R  = 8'h52;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  // Line parser states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIGITS = 2'd1,
    SKIP   = 2'd2
  } state_t;

  // One BCD digit
  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/bcd_digit_shift3.sv
// rtl/bcd_digit_shift3.sv - three-digit BCD shift register with clear and overflow flag
module bcd_digit_shift3
  import dial_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic shift,
  input  bcd_t din,
  output bcd_t h_nxt,
  output bcd_t t_nxt,
  output bcd_t o_nxt,
  output logic overflow
);

  bcd_t h, t, o;

  // Next-digit view is exported so the parser can emit the value including
  // a digit that arrives on the same cycle as end-of-file.
  always_comb begin
    h_nxt    = h;
    t_nxt    = t;
    o_nxt    = o;
    overflow = 1'b0;
    if (clear) begin
      h_nxt = '0;
      t_nxt = '0;
      o_nxt = '0;
    end else if (shift) begin
      h_nxt    = t;
      t_nxt    = o;
      o_nxt    = din;
      overflow = (h != '0);
    end
  end

  // Digit storage
  always_ff @(posedge clk) begin
    if (rst) begin
      h <= '0;
      t <= '0;
      o <= '0;
    end else begin
      h <= h_nxt;
      t <= t_nxt;
      o <= o_nxt;
    end
  end

endmodule

// File: rtl/rotation_line_parser.sv
// rtl/rotation_line_parser.sv - ASCII "L68"/"R5" line stream to BCD rotation pulses
module rotation_line_parser
  import dial_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             rot_valid,
  output logic             R_L,
  output logic [7:0]       BCD_val,
  output logic [3:0]       BCD_mod,
  output logic [CNT_W-1:0] rot_count,
  output logic             done,
  output logic             err_syntax,
  output logic             err_overflow
);

  state_t state, state_nxt;
  logic   dir, dir_nxt;
  logic   seen, seen_nxt;
  logic   dclear, dshift;
  logic   syn, emit, ovf;
  logic   accept, is_digit;
  bcd_t   h_nxt, t_nxt, o_nxt;

  assign accept   = in_valid && in_ready;
  assign is_digit = (in_byte >= CH_0) && (in_byte <= CH_9);

  // Low nibble of '0'..'9' is already the BCD digit value
  bcd_digit_shift3 u_digits (
    .clk      (clk),
    .rst      (rst),
    .clear    (dclear),
    .shift    (dshift),
    .din      (in_byte[3:0]),
    .h_nxt    (h_nxt),
    .t_nxt    (t_nxt),
    .o_nxt    (o_nxt),
    .overflow (ovf)
  );

  // Decode the accepted byte, then fold in end-of-file as an implied newline
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    seen_nxt  = seen;
    dclear    = 1'b0;
    dshift    = 1'b0;
    syn       = 1'b0;
    emit      = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (in_byte == CH_L || in_byte == CH_R) begin
            dir_nxt   = (in_byte == CH_L);
            seen_nxt  = 1'b0;
            dclear    = 1'b1;
            state_nxt = DIGITS;
          end else if (in_byte != CH_LF && in_byte != CH_CR) begin
            syn       = 1'b1;
            state_nxt = SKIP;
          end
        end
        DIGITS: begin
          if (is_digit) begin
            dshift   = 1'b1;
            seen_nxt = 1'b1;
          end else if (in_byte == CH_CR) begin
            state_nxt = DIGITS;
          end else if (in_byte == CH_LF) begin
            if (seen) emit = 1'b1;
            else      syn  = 1'b1;
            state_nxt = IDLE;
          end else begin
            syn       = 1'b1;
            state_nxt = SKIP;
          end
        end
        SKIP: begin
          if (in_byte == CH_LF) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
      if (in_last) begin
        if (state_nxt == DIGITS) begin
          if (seen_nxt) emit = 1'b1;
          else          syn  = 1'b1;
        end
        state_nxt = IDLE;
      end
    end
  end

  // Parser state and registered outputs; rotation fields are zero unless emitting
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dir          <= 1'b0;
      seen         <= 1'b0;
      in_ready     <= 1'b0;
      rot_valid    <= 1'b0;
      R_L          <= 1'b0;
      BCD_val      <= '0;
      BCD_mod      <= '0;
      rot_count    <= '0;
      done         <= 1'b0;
      err_syntax   <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      seen         <= seen_nxt;
      in_ready     <= 1'b1;
      rot_valid    <= emit;
      R_L          <= emit & dir_nxt;
      BCD_val      <= emit ? {t_nxt, o_nxt} : 8'h00;
      BCD_mod      <= emit ? h_nxt : 4'h0;
      rot_count    <= rot_count + CNT_W'(emit);
      done         <= accept && in_last;
      err_syntax   <= err_syntax | syn;
      err_overflow <= err_overflow | ovf;
    end
  end

endmodule
